// File: rtl/sbox_share_arbiter.sv
// Round-robin arbiter that shares one pipelined AES S-box (forward or inverse) among NREQ requesters.
// Inversion runs in GF((2^4)^2); the basis maps to and from it are derived at elaboration time.
module sbox_share_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 3,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_dec,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_data,
    output logic              busy
);
    // Datapath steps: pre-affine, basis map, GF inverse, inverse map, post-affine.
    localparam int K = 5;

    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [3:0] gf4_inv(input logic [3:0] a);
        logic [3:0] a2, a4, a8;
        a2 = gf4_mul(a, a);
        a4 = gf4_mul(a2, a2);
        a8 = gf4_mul(a4, a4);
        return gf4_mul(gf4_mul(a2, a4), a8);
    endfunction

    // y^2 + y + lam must be irreducible over GF(16): lam has no t with t^2 + t = lam.
    function automatic logic [3:0] find_lambda();
        logic [3:0] res;
        logic       hit;
        res = '0;
        for (int l = 15; l >= 1; l--) begin
            hit = 1'b0;
            for (int t = 0; t < 16; t++)
                if ((gf4_mul(4'(t), 4'(t)) ^ 4'(t)) == 4'(l)) hit = 1'b1;
            if (!hit) res = 4'(l);
        end
        return res;
    endfunction

    function automatic logic [7:0] gf8c_mul(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] lam);
        logic [3:0] hh;
        hh = gf4_mul(a[7:4], b[7:4]);
        return {hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]),
                gf4_mul(hh, lam) ^ gf4_mul(a[3:0], b[3:0])};
    endfunction

    // Composite-field root of the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] find_beta(input logic [3:0] lam);
        logic [7:0] res, b, p2, p3, p4, p8;
        res = '0;
        for (int i = 255; i >= 2; i--) begin
            b  = 8'(i);
            p2 = gf8c_mul(b, b, lam);
            p3 = gf8c_mul(p2, b, lam);
            p4 = gf8c_mul(p2, p2, lam);
            p8 = gf8c_mul(p4, p4, lam);
            if ((p8 ^ p4 ^ p3 ^ b ^ 8'h01) == 8'h00) res = b;
        end
        return res;
    endfunction

    function automatic logic [7:0] gf_map(input logic [63:0] m, input logic [7:0] v);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (v[i]) r = r ^ m[8*i +: 8];
        return r;
    endfunction

    function automatic logic [63:0] calc_iso(input logic [3:0] lam);
        logic [63:0] m;
        logic [7:0]  b, p;
        b = find_beta(lam);
        p = 8'h01;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = p;
            p = gf8c_mul(p, b, lam);
        end
        return m;
    endfunction

    function automatic logic [63:0] calc_inv(input logic [63:0] m);
        logic [63:0] r;
        logic [7:0]  c;
        r = '0;
        for (int a = 0; a < 256; a++) begin
            c = gf_map(m, 8'(a));
            for (int j = 0; j < 8; j++)
                if (c == (8'h01 << j)) r[8*j +: 8] = 8'(a);
        end
        return r;
    endfunction

    localparam logic [3:0]  LAM     = find_lambda();
    localparam logic [63:0] ISO     = calc_iso(LAM);
    localparam logic [63:0] ISO_INV = calc_inv(ISO);

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] gf8c_inv(input logic [7:0] a);
        logic [3:0] d, di;
        d  = gf4_mul(gf4_mul(a[7:4], a[7:4]), LAM) ^ gf4_mul(a[7:4], a[3:0])
           ^ gf4_mul(a[3:0], a[3:0]);
        di = gf4_inv(d);
        return {gf4_mul(a[7:4], di), gf4_mul(a[7:4] ^ a[3:0], di)};
    endfunction

    function automatic logic [7:0] dp_step(input int k, input logic [7:0] v, input logic dec);
        logic [7:0] r;
        r = v;
        case (k)
            0:       r = dec ? (rotl(v, 1) ^ rotl(v, 3) ^ rotl(v, 6) ^ 8'h05) : v;
            1:       r = gf_map(ISO, v);
            2:       r = gf8c_inv(v);
            3:       r = gf_map(ISO_INV, v);
            default: r = dec ? v : (v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63);
        endcase
        return r;
    endfunction

    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] gnt_idx, scan_idx;
    logic           gnt_found;
    logic           accept;
    logic [7:0]     req_byte [NREQ];

    logic [LAT:0]   vld_pipe_q;
    logic [7:0]     st_q [LAT];
    logic [7:0]     seg  [LAT];
    logic [IDW-1:0] id_q [LAT];
    logic [LAT-1:0] dec_q;
    logic [IDW-1:0] rsp_id_q;
    logic [7:0]     rsp_data_q;
    logic           busy_q;

    for (genvar i = 0; i < NREQ; i++) begin : g_byte
        assign req_byte[i] = req_data[8*i +: 8];
    end

    // Scan from farthest to nearest so the closest valid requester after last_q wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            scan_idx = IDW'((int'(last_q) + k) % NREQ);
            if (req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (en && rst_n && gnt_found) req_ready[gnt_idx] = 1'b1;
    end

    assign accept = |(req_valid & req_ready);
    assign last_d = accept ? gnt_idx : last_q;

    // Segment s applies every step k with floor(k*LAT/K) == s.
    for (genvar s = 0; s < LAT; s++) begin : g_seg
        logic [7:0] v;
        always_comb begin
            v = st_q[s];
            for (int k = 0; k < K; k++)
                if (k * LAT / K == s) v = dp_step(k, v, dec_q[s]);
        end
        assign seg[s] = v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= IDW'(NREQ - 1);
            vld_pipe_q <= '0;
            busy_q     <= 1'b0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            dec_q      <= '0;
            for (int s = 0; s < LAT; s++) begin
                st_q[s] <= '0;
                id_q[s] <= '0;
            end
        end else begin
            last_q     <= last_d;
            vld_pipe_q <= {vld_pipe_q[LAT-1:0], accept};
            busy_q     <= accept | (|vld_pipe_q[LAT-1:0]);
            if (accept) begin
                st_q[0]  <= req_byte[gnt_idx];
                id_q[0]  <= gnt_idx;
                dec_q[0] <= req_dec[gnt_idx];
            end
            for (int s = 1; s < LAT; s++) begin
                st_q[s]  <= seg[s-1];
                id_q[s]  <= id_q[s-1];
                dec_q[s] <= dec_q[s-1];
            end
            if (vld_pipe_q[LAT-1]) begin
                rsp_data_q <= seg[LAT-1];
                rsp_id_q   <= id_q[LAT-1];
            end
        end
    end

    assign rsp_valid = vld_pipe_q[LAT];
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

endmodule
